strobe_row_sequencer: RTL

Sequences per-row pixel configuration for the Mic4 pixel matrix.
- For each row it requests a configuration shift from the shifter and waits for the shifter's done/valid_out rising edge.
- It then waits a programmable number of clock cycles and drives the active-low strobe_b pulse for a programmable width.
- After the pulse it advances to the next row.
- It sits between the slow-control register block (start, row count, timing) and the row shifter / strobe_b pad driver.

---
 rtl/strobe_row_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/strobe_row_sequencer.sv
// -----------------------------------------------------------------------------
// strobe_row_sequencer
//
// Walks the Mic4 pixel matrix one row at a time. For every row it asks the row
// shifter to load the row configuration and waits for the shifter to report
// completion. It then waits a programmable delay and drives the active-low
// strobe_b pulse for a programmable width before moving on to the next row.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       one-cycle run request (ignored while busy)
//   i_abort       synchronous run abort, wins over everything except reset
//   i_n_rows      rows to configure, latched on an accepted start
//   i_delay       cycles from the shift_done rise to the strobe_b fall
//   i_width       strobe_b low time in cycles (0 behaves as 1)
//   o_shift_req   request to the shifter to load o_row_addr
//   i_shift_ack   shifter accepted the request
//   i_shift_done  shifter valid_out; only its rising edge is used
//   o_row_addr    row currently being configured
//   o_strobe_b    active-low strobe to the pad driver
//   o_busy        high whenever the sequencer is not idle
//   o_done        one-cycle pulse after the last row's strobe
//   o_err         sticky shifter timeout flag
// -----------------------------------------------------------------------------
module strobe_row_sequencer #(
  parameter int ROW_W   = 7,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [ROW_W-1:0] i_n_rows,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_shift_req,
  input  logic             i_shift_ack,
  input  logic             i_shift_done,
  output logic [ROW_W-1:0] o_row_addr,
  output logic             o_strobe_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SHIFT,
    S_DELAY,
    S_STROBE,
    S_NEXT
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_n_rows;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_cnt;        // shared by the DELAY and STROBE phases
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_done_prev;

  logic w_rise;
  logic w_last;
  logic w_timeout;

  // A level held high on shift_done never retriggers; only a fresh 0->1 counts.
  assign w_rise    = i_shift_done & ~r_done_prev;
  assign w_last    = (o_row_addr == (r_n_rows - ROW_W'(1)));
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_n_rows    <= '0;
      r_delay     <= '0;
      r_width     <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_done_prev <= 1'b0;
      o_shift_req <= 1'b0;
      o_row_addr  <= '0;
      o_strobe_b  <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_done_prev <= i_shift_done;
      o_done      <= 1'b0;

      if (i_abort) begin
        // Abort also masks a coincident start in IDLE; err and row_addr keep
        // their values so software can see where the run stopped.
        r_state     <= S_IDLE;
        o_strobe_b  <= 1'b1;
        o_shift_req <= 1'b0;
        o_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              o_err <= 1'b0;
              if (i_n_rows != '0) begin
                r_n_rows    <= i_n_rows;
                r_delay     <= i_delay;
                r_width     <= (i_width == '0) ? CNT_W'(1) : i_width;
                r_to_cnt    <= '0;
                o_row_addr  <= '0;
                o_shift_req <= 1'b1;
                o_busy      <= 1'b1;
                r_state     <= S_REQ;
              end else begin
                // Empty run: report completion without touching the shifter.
                o_done <= 1'b1;
              end
            end
          end

          S_REQ: begin
            if (w_timeout) begin
              o_err       <= 1'b1;
              o_shift_req <= 1'b0;
              o_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
              if (i_shift_ack) begin
                o_shift_req <= 1'b0;
                r_state     <= S_SHIFT;
              end
            end
          end

          S_SHIFT: begin
            // A rise on the very last allowed cycle still counts as in time.
            if (w_rise) begin
              r_cnt   <= r_delay;
              r_state <= S_DELAY;
            end else if (w_timeout) begin
              o_err       <= 1'b1;
              o_shift_req <= 1'b0;
              o_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end

          S_DELAY: begin
            // Zero delay still spends one cycle here, so the strobe fall is
            // always delay+1 edges after the shift_done rise was sampled.
            if (r_cnt == '0) begin
              o_strobe_b <= 1'b0;
              r_cnt      <= r_width - CNT_W'(1);
              r_state    <= S_STROBE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end

          S_STROBE: begin
            if (r_cnt == '0) begin
              o_strobe_b <= 1'b1;
              r_state    <= S_NEXT;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end

          S_NEXT: begin
            if (w_last) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              o_row_addr  <= o_row_addr + ROW_W'(1);
              o_shift_req <= 1'b1;
              r_to_cnt    <= '0;
              r_state     <= S_REQ;
            end
          end

          default: begin
            o_strobe_b  <= 1'b1;
            o_shift_req <= 1'b0;
            o_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
